// File: rtl/datapath_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_mc_pkg
// Purpose  : FSM state encodings, funct3 flag-select codes and flag mux helper
//            shared by the multi-cycle datapath.
// Revision : 1.0 - initial release
// ============================================================================
package datapath_mc_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_IDLE = 3'd0;
    localparam state_t c_RD   = 3'd1;
    localparam state_t c_EX   = 3'd2;
    localparam state_t c_MEM  = 3'd3;
    localparam state_t c_WB   = 3'd4;
    localparam state_t c_DONE = 3'd5;

    localparam logic [2:0] c_F3_EQ  = 3'b000;
    localparam logic [2:0] c_F3_NE  = 3'b001;
    localparam logic [2:0] c_F3_LT  = 3'b100;
    localparam logic [2:0] c_F3_GE  = 3'b101;
    localparam logic [2:0] c_F3_LTU = 3'b110;
    localparam logic [2:0] c_F3_GEU = 3'b111;

    // Codes 010/011 have no compare meaning and yield 0.
    function automatic logic selectFlag(
        input logic [2:0] funct3,
        input logic       isEq,
        input logic       isLt,
        input logic       isLtu
    );
        logic flag;
        flag = 1'b0;
        case (funct3)
            c_F3_EQ:  flag = isEq;
            c_F3_NE:  flag = ~isEq;
            c_F3_LT:  flag = isLt;
            c_F3_GE:  flag = ~isLt;
            c_F3_LTU: flag = isLtu;
            c_F3_GEU: flag = ~isLtu;
            default:  flag = 1'b0;
        endcase
        return flag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w
// Purpose  : Register file, two combinational reads and one synchronous write;
//            entry 0 is hard-wired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    localparam int RAW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RAW-1:0]  i_rs1Addr,
    input  logic [RAW-1:0]  i_rs2Addr,
    output logic [XLEN-1:0] o_rs1Data,
    output logic [XLEN-1:0] o_rs2Data,
    input  logic            i_writeEn,
    input  logic [RAW-1:0]  i_writeAddr,
    input  logic [XLEN-1:0] i_writeData
);

    logic [XLEN-1:0] w_regs [NREG];

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign w_regs[i] = '0;
        end else begin : g_flop
            logic [XLEN-1:0] r_value;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_value <= '0;
                end else if (i_writeEn && (i_writeAddr == RAW'(i))) begin
                    r_value <= i_writeData;
                end
            end

            assign w_regs[i] = r_value;
        end
    end

    assign o_rs1Data = w_regs[i_rs1Addr];
    assign o_rs2Data = w_regs[i_rs2Addr];

endmodule
`default_nettype wire

// File: rtl/datapath_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : datapath_multicycle
// Purpose  : Multi-cycle datapath executing one pre-decoded operation per
//            start/done handshake (RD -> EX -> MEM/WB -> DONE).
// Revision : 1.0 - initial release
// ============================================================================
module datapath_multicycle
    import datapath_mc_pkg::*;
#(
    parameter  int XLEN  = 64,
    parameter  int NREG  = 32,
    parameter  int DEPTH = 256,
    localparam int RAW   = $clog2(NREG),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [RAW-1:0]  rs1,
    input  logic [RAW-1:0]  rs2,
    input  logic [RAW-1:0]  rd,
    input  logic [XLEN-1:0] immediate,
    input  logic [2:0]      funct3,
    input  logic            alu_sub,
    input  logic            sel_imm,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            reg_write,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            selected_flag
);

    state_t          r_state;
    state_t          w_nextState;

    logic [RAW-1:0]  r_cmdRs1;
    logic [RAW-1:0]  r_cmdRs2;
    logic [RAW-1:0]  r_cmdRd;
    logic [XLEN-1:0] r_cmdImm;
    logic [2:0]      r_cmdFunct3;
    logic            r_cmdSub;
    logic            r_cmdSelImm;
    logic            r_cmdMemWrite;
    logic            r_cmdMemToReg;
    logic            r_cmdRegWrite;

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_aluOut;
    logic [XLEN-1:0] r_mdr;
    logic [XLEN-1:0] r_result;
    logic            r_selFlag;

    logic [XLEN-1:0] w_rs1Data;
    logic [XLEN-1:0] w_rs2Data;
    logic [XLEN-1:0] w_opB;
    logic [XLEN-1:0] w_aluSum;
    logic            w_isEq;
    logic            w_isLt;
    logic            w_isLtu;
    logic [AW-1:0]   w_memAddr;
    logic [XLEN-1:0] w_wbData;
    logic            w_regWe;
    logic            w_accept;

    logic [XLEN-1:0] r_mem [DEPTH];

    assign w_accept = start && (r_state == c_IDLE);

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rs1Addr   (r_cmdRs1),
        .i_rs2Addr   (r_cmdRs2),
        .o_rs1Data   (w_rs1Data),
        .o_rs2Data   (w_rs2Data),
        .i_writeEn   (w_regWe),
        .i_writeAddr (r_cmdRd),
        .i_writeData (w_wbData)
    );

    assign w_opB    = r_cmdSelImm ? r_cmdImm : r_b;
    assign w_aluSum = r_cmdSub ? (r_a - w_opB) : (r_a + w_opB);
    assign w_isEq   = (r_a == w_opB);
    assign w_isLt   = ($signed(r_a) < $signed(w_opB));
    assign w_isLtu  = (r_a < w_opB);

    assign w_memAddr = r_aluOut[AW-1:0];
    assign w_wbData  = r_cmdMemToReg ? r_mdr : r_aluOut;
    assign w_regWe   = (r_state == c_WB) && r_cmdRegWrite && (r_cmdRd != '0);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: if (start) w_nextState = c_RD;
            c_RD:   w_nextState = c_EX;
            c_EX: begin
                if (r_cmdMemWrite || r_cmdMemToReg) begin
                    w_nextState = c_MEM;
                end else if (r_cmdRegWrite) begin
                    w_nextState = c_WB;
                end else begin
                    w_nextState = c_DONE;
                end
            end
            // Store wins when both memory controls are set: no load, no write-back.
            c_MEM:  w_nextState = r_cmdMemWrite ? c_DONE : c_WB;
            c_WB:   w_nextState = c_DONE;
            c_DONE: w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_cmdRs1      <= '0;
            r_cmdRs2      <= '0;
            r_cmdRd       <= '0;
            r_cmdImm      <= '0;
            r_cmdFunct3   <= '0;
            r_cmdSub      <= 1'b0;
            r_cmdSelImm   <= 1'b0;
            r_cmdMemWrite <= 1'b0;
            r_cmdMemToReg <= 1'b0;
            r_cmdRegWrite <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_cmdRs1      <= rs1;
                r_cmdRs2      <= rs2;
                r_cmdRd       <= rd;
                r_cmdImm      <= immediate;
                r_cmdFunct3   <= funct3;
                r_cmdSub      <= alu_sub;
                r_cmdSelImm   <= sel_imm;
                r_cmdMemWrite <= mem_write;
                r_cmdMemToReg <= mem_to_reg;
                r_cmdRegWrite <= reg_write;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_aluOut  <= '0;
            r_mdr     <= '0;
            r_result  <= '0;
            r_selFlag <= 1'b0;
        end else begin
            case (r_state)
                c_RD: begin
                    r_a <= w_rs1Data;
                    r_b <= w_rs2Data;
                end
                c_EX: begin
                    r_aluOut  <= w_aluSum;
                    r_selFlag <= selectFlag(r_cmdFunct3, w_isEq, w_isLt, w_isLtu);
                end
                c_MEM: begin
                    if (!r_cmdMemWrite) begin
                        r_mdr <= r_mem[w_memAddr];
                    end
                end
                c_WB: begin
                    if (r_cmdRegWrite) begin
                        r_result <= w_wbData;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is not reset; the only write is on the MEM edge, so an abort never tears a store.
    always_ff @(posedge clk) begin
        if ((r_state == c_MEM) && r_cmdMemWrite) begin
            r_mem[w_memAddr] <= r_b;
        end
    end

    assign busy          = (r_state != c_IDLE);
    assign done          = (r_state == c_DONE);
    assign result        = r_result;
    assign selected_flag = r_selFlag;

endmodule
`default_nettype wire

// File: tb/tb_datapath_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_multicycle
// Purpose  : Self-checking bench: vector table plus hand-written reset-abort and
//            held-start sequences, compared through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_multicycle;

    localparam int XLEN  = 64;
    localparam int NREG  = 32;
    localparam int DEPTH = 256;

    localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_MINN = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [2:0]  f3;
        logic        sub;
        logic        selImm;
        logic        mw;
        logic        m2r;
        logic        rw;
        logic [63:0] expRes;
        logic        expFlag;
        int          expLat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        flag;
        int          lat;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] immediate;
    logic [2:0]  funct3;
    logic        alu_sub, sel_imm, mem_write, mem_to_reg, reg_write;
    logic        busy, done, selected_flag;
    logic [63:0] result;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    datapath_multicycle #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .immediate     (immediate),
        .funct3        (funct3),
        .alu_sub       (alu_sub),
        .sel_imm       (sel_imm),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .selected_flag (selected_flag)
    );

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d got %h want %h", nm, id, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                input logic [63:0] imm, input logic [2:0] f3, input logic sub,
                                input logic si, input logic mw, input logic m2r, input logic rw,
                                input logic [63:0] er, input logic ef, input int el);
        vec_t v;
        v.rs1 = a; v.rs2 = b; v.rd = d; v.imm = imm; v.f3 = f3; v.sub = sub;
        v.selImm = si; v.mw = mw; v.m2r = m2r; v.rw = rw;
        v.expRes = er; v.expFlag = ef; v.expLat = el;
        return v;
    endfunction

    task automatic driveCmd(input vec_t v);
        rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; immediate = v.imm; funct3 = v.f3;
        alu_sub = v.sub; sel_imm = v.selImm; mem_write = v.mw;
        mem_to_reg = v.m2r; reg_write = v.rw;
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (busy) chk("idle_timeout", 0, 64'(busy), 64'd0);
    endtask

    // Issue one op, then compare latency, busy, result and flag against the scoreboard head.
    task automatic runOp(input vec_t v, input int id);
        int   cyc;
        logic got;
        exp_t e;
        waitIdle();
        driveCmd(v);
        start = 1'b1;
        sb.push_back('{v.expRes, v.expFlag, v.expLat, id});
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (!busy) chk("busy_during_op", id, 64'(busy), 64'd1);
            if (done) got = 1'b1;
        end
        e = sb.pop_front();
        chk("done_latency", e.id, 64'(got ? cyc : -1), 64'(e.lat));
        chk("result", e.id, result, e.res);
        chk("flag", e.id, 64'(selected_flag), 64'(e.flag));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout #0 got %0t want <2ms", $time);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   nDone;
        vec_t v;

        rst_n = 1'b0;
        start = 1'b0;
        driveCmd(mk(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        chk("reset_busy", 0, 64'(busy), 64'd0);
        chk("reset_done", 0, 64'(done), 64'd0);
        chk("reset_result", 0, result, 64'd0);
        chk("reset_flag", 0, 64'(selected_flag), 64'd0);
        rst_n = 1'b1;

        // Dirty some state, then abort an op in EX with reset.
        runOp(mk(0, 0, 4, 64'd9, 3'b000, 0, 1, 0, 0, 1, 64'd9, 0, 4), 1);
        runOp(mk(4, 0, 31, 64'd3, 3'b001, 0, 1, 0, 0, 1, 64'd12, 1, 4), 2);
        waitIdle();
        driveCmd(mk(0, 0, 5, 64'd100, 3'b000, 0, 1, 0, 0, 1, 0, 0, 0));
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 3, 64'(busy), 64'd0);
        chk("abort_done", 3, 64'(done), 64'd0);
        chk("abort_result", 3, result, 64'd0);
        chk("abort_flag", 3, 64'(selected_flag), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < NREG; i++) begin
            runOp(mk(5'(i), 0, 0, 64'd0, 3'b000, 0, 1, 0, 0, 1, 64'd0, 1, 4), 100 + i);
        end

        vecs.push_back(mk(0, 0, 1, 64'd5,     3'b000, 0, 1, 0, 0, 1, 64'd5,    0, 4));
        vecs.push_back(mk(1, 0, 0, 64'd0,     3'b000, 0, 1, 0, 0, 1, 64'd5,    0, 4));
        vecs.push_back(mk(0, 1, 0, 64'h10F,   3'b001, 0, 1, 1, 0, 0, 64'd5,    1, 4));
        vecs.push_back(mk(0, 0, 0, 64'h55,    3'b000, 0, 1, 0, 0, 1, 64'h55,   0, 4));
        vecs.push_back(mk(0, 0, 0, 64'd0,     3'b000, 0, 1, 0, 0, 1, 64'd0,    1, 4));
        vecs.push_back(mk(0, 0, 2, 64'h0F,    3'b000, 0, 1, 0, 1, 1, 64'd5,    0, 5));
        vecs.push_back(mk(2, 0, 0, 64'd0,     3'b101, 0, 1, 0, 0, 1, 64'd5,    1, 4));
        vecs.push_back(mk(0, 0, 3, c_ONES,    3'b100, 0, 1, 0, 0, 1, c_ONES,   0, 4));
        vecs.push_back(mk(3, 1, 0, 64'd0,     3'b100, 1, 0, 0, 0, 0, c_ONES,   1, 3));
        vecs.push_back(mk(3, 1, 0, 64'd0,     3'b110, 1, 0, 0, 0, 0, c_ONES,   0, 3));
        vecs.push_back(mk(3, 1, 0, 64'd0,     3'b000, 1, 0, 0, 0, 0, c_ONES,   0, 3));
        vecs.push_back(mk(3, 1, 0, 64'd0,     3'b001, 1, 0, 0, 0, 0, c_ONES,   1, 3));
        vecs.push_back(mk(3, 1, 0, 64'd0,     3'b010, 1, 0, 0, 0, 0, c_ONES,   0, 3));
        vecs.push_back(mk(3, 1, 0, 64'd0,     3'b101, 1, 0, 0, 0, 0, c_ONES,   0, 3));
        vecs.push_back(mk(3, 1, 0, 64'd0,     3'b111, 1, 0, 0, 0, 0, c_ONES,   1, 3));
        vecs.push_back(mk(0, 0, 4, c_MAXP,    3'b111, 0, 1, 0, 0, 1, c_MAXP,   0, 4));
        vecs.push_back(mk(4, 0, 5, 64'd1,     3'b101, 0, 1, 0, 0, 1, c_MINN,   1, 4));
        vecs.push_back(mk(1, 3, 6, 64'd0,     3'b110, 1, 0, 0, 0, 1, 64'd6,    1, 4));
        vecs.push_back(mk(0, 1, 7, 64'h20,    3'b000, 0, 1, 1, 1, 1, 64'd6,    0, 4));
        vecs.push_back(mk(0, 0, 8, 64'h20,    3'b000, 0, 1, 0, 1, 1, 64'd5,    0, 5));
        vecs.push_back(mk(7, 0, 0, 64'd0,     3'b000, 0, 1, 0, 0, 1, 64'd0,    1, 4));
        vecs.push_back(mk(0, 0, 9, 64'h120,   3'b000, 0, 1, 0, 1, 1, 64'd5,    0, 5));
        vecs.push_back(mk(5, 4, 0, 64'd0,     3'b100, 1, 0, 0, 0, 0, 64'd5,    1, 3));
        foreach (vecs[i]) runOp(vecs[i], 200 + i);

        // start held high: x10 += 1 repeatedly, one accept per IDLE visit.
        waitIdle();
        v = mk(10, 0, 10, 64'd1, 3'b000, 0, 1, 0, 0, 1, 0, 0, 0);
        driveCmd(v);
        start = 1'b1;
        for (int k = 1; k <= 4; k++) sb.push_back('{64'(k), (k == 2), 4, 300 + k});
        nDone = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 16) start = 1'b0;
            chk("held_busy", 400 + n, 64'(busy), 64'((n < 20) && (n % 5 != 0)));
            chk("held_done", 400 + n, 64'(done), 64'((n < 20) && (n % 5 == 4)));
            if (done && sb.size() > 0) begin
                nDone++;
                e = sb.pop_front();
                chk("held_result", e.id, result, e.res);
                chk("held_flag", e.id, 64'(selected_flag), 64'(e.flag));
            end
        end
        chk("held_count", 400, 64'(nDone), 64'd4);
        sb.delete();
        runOp(mk(10, 0, 0, 64'd0, 3'b000, 0, 1, 0, 0, 1, 64'd4, 0, 4), 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
